// File: rtl/alu_input_loader.sv
// ---------------------------------------------------------------------------
// alu_input_loader
// Collects two operands and an operation from front-panel switches, one item
// per debounced press of the load button, and presents them to an ALU.
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   sw[N-1:0]          raw operand switches, captured on a load press
//   op_sw[2:0]         raw operation switches, captured on the third press
//   btn_load           raw bouncy load button (active-high)
//   btn_clear          raw bouncy clear button (active-high)
//   a, b[N-1:0]        registered operands
//   op[2:0]            registered operation select
//   valid              high while in READY (complete operand set)
//   stage[1:0]         current state code for LEDs
// ---------------------------------------------------------------------------
module alu_input_loader #(
    parameter int unsigned N          = 4,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    input  logic [2:0]   op_sw,
    input  logic         btn_load,
    input  logic         btn_clear,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [2:0]   op,
    output logic         valid,
    output logic [1:0]   stage
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned NBTN  = 2;
    localparam int unsigned BTN_LOAD  = 0;
    localparam int unsigned BTN_CLEAR = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [1:0] ST_LOAD_A  = 2'b00;
    localparam logic [1:0] ST_LOAD_B  = 2'b01;
    localparam logic [1:0] ST_LOAD_OP = 2'b10;
    localparam logic [1:0] ST_READY   = 2'b11;

    logic [NBTN-1:0]  w_btn_raw;
    logic [NBTN-1:0]  r_sync1;
    logic [NBTN-1:0]  r_sync2;
    logic [NBTN-1:0]  r_deb;
    logic [NBTN-1:0]  r_press;
    logic [CNT_W-1:0] r_cnt [NBTN];

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic         w_cap_a;
    logic         w_cap_b;
    logic         w_cap_op;
    logic         w_load;
    logic         w_clear;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [2:0]   r_op;
    logic         r_valid;

    assign w_btn_raw = {btn_clear, btn_load};

    // Two-flop synchronizers for the asynchronous button inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: the level flips only after DEB_CYCLES consecutive mismatching
    // samples; r_press is a one-cycle pulse on each debounced 0->1 flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb   <= '0;
            r_press <= '0;
            for (int i = 0; i < NBTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_deb[i]   <= r_sync2[i];
                        r_press[i] <= r_sync2[i];
                        r_cnt[i]   <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_load  = r_press[BTN_LOAD];
    assign w_clear = r_press[BTN_CLEAR];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and capture enables; clear overrides a simultaneous load
    always_comb begin
        w_next_state = r_state;
        w_cap_a      = 1'b0;
        w_cap_b      = 1'b0;
        w_cap_op     = 1'b0;
        if (w_clear) begin
            w_next_state = ST_LOAD_A;
        end else if (w_load) begin
            case (r_state)
                ST_LOAD_A: begin
                    w_cap_a      = 1'b1;
                    w_next_state = ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    w_cap_b      = 1'b1;
                    w_next_state = ST_LOAD_OP;
                end
                ST_LOAD_OP: begin
                    w_cap_op     = 1'b1;
                    w_next_state = ST_READY;
                end
                ST_READY: begin
                    w_next_state = ST_LOAD_A;
                end
                default: begin
                    w_next_state = ST_LOAD_A;
                end
            endcase
        end
    end

    // Operand registers and valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (w_next_state == ST_READY);
            if (w_clear) begin
                r_a  <= '0;
                r_b  <= '0;
                r_op <= '0;
            end else begin
                if (w_cap_a) begin
                    r_a <= sw;
                end
                if (w_cap_b) begin
                    r_b <= sw;
                end
                if (w_cap_op) begin
                    r_op <= op_sw;
                end
            end
        end
    end

    assign a     = r_a;
    assign b     = r_b;
    assign op    = r_op;
    assign valid = r_valid;
    assign stage = r_state;

endmodule

// File: tb/tb_alu_input_loader.sv
// ---------------------------------------------------------------------------
// tb_alu_input_loader
// Table-driven and random checks of alu_input_loader (N=4, DEB_CYCLES=4)
// against a window-based behavioural model of debounce and operand loading.
// ---------------------------------------------------------------------------
module tb_alu_input_loader;

    localparam int unsigned N   = 4;
    localparam int unsigned DEB = 4;
    localparam int unsigned HW  = DEB + 2;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] sw;
    logic [2:0]   op_sw;
    logic         btn_load;
    logic         btn_clear;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         valid;
    logic [1:0]   stage;

    int n_chk;
    int n_fail;

    // Behavioural model state
    int ma, mb, mop, mst;
    bit hist [2][HW];
    bit mdeb [2];
    bit mpls [2];

    alu_input_loader #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .op_sw     (op_sw),
        .btn_load  (btn_load),
        .btn_clear (btn_clear),
        .a         (a),
        .b         (b),
        .op        (op),
        .valid     (valid),
        .stage     (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sw;
        logic [2:0] op_sw;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [2:0] eop;
        logic [1:0] est;
        logic       ev;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ma = 0; mb = 0; mop = 0; mst = 0;
        for (int k = 0; k < 2; k++) begin
            mdeb[k] = 1'b0;
            mpls[k] = 1'b0;
            for (int j = 0; j < HW; j++) hist[k][j] = 1'b0;
        end
    endtask

    // One rising edge of the model: act on last edge's pulses, then debounce.
    // A level flips when the DEB raw samples taken 2..DEB+1 edges ago all
    // disagree with it (two edges of synchronizer delay).
    task automatic model_step();
        bit raw [2];
        bit flip;
        if (mpls[1]) begin
            ma = 0; mb = 0; mop = 0; mst = 0;
        end else if (mpls[0]) begin
            case (mst)
                0: begin ma  = int'(sw);    mst = 1; end
                1: begin mb  = int'(sw);    mst = 2; end
                2: begin mop = int'(op_sw); mst = 3; end
                default: mst = 0;
            endcase
        end
        raw[0] = btn_load;
        raw[1] = btn_clear;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < HW - 1; j++) hist[k][j] = hist[k][j+1];
            hist[k][HW-1] = raw[k];
            flip = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (hist[k][j] == mdeb[k]) flip = 1'b0;
            end
            mpls[k] = 1'b0;
            if (flip) begin
                mdeb[k] = ~mdeb[k];
                mpls[k] = mdeb[k];
            end
        end
    endtask

    task automatic check_model();
        chk("model_a",     32'(a),     32'(ma));
        chk("model_b",     32'(b),     32'(mb));
        chk("model_op",    32'(op),    32'(mop));
        chk("model_stage", 32'(stage), 32'(mst));
        chk("model_valid", 32'(valid), 32'(mst == 3));
    endtask

    // Inputs change at negedge; DUT and model both act on the next posedge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_a",     32'(a),     32'h0);
        chk("rst_b",     32'(b),     32'h0);
        chk("rst_op",    32'(op),    32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_stage", 32'(stage), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press_load(input int hold);
        btn_load = 1'b1;
        repeat (hold) tick();
        btn_load = 1'b0;
        repeat (DEB + 4) tick();
    endtask

    task automatic press_clear(input int hold);
        btn_clear = 1'b1;
        repeat (hold) tick();
        btn_clear = 1'b0;
        repeat (DEB + 4) tick();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        sw = '0;
        op_sw = '0;
        btn_load = 1'b0;
        btn_clear = 1'b0;
        model_reset();

        //              sw     op_sw   a      b      op     stage  valid
        vecs[0] = '{4'h4, 3'd0, 4'h4, 4'h0, 3'd0, 2'd1, 1'b0};
        vecs[1] = '{4'h3, 3'd0, 4'h4, 4'h3, 3'd0, 2'd2, 1'b0};
        vecs[2] = '{4'h9, 3'd0, 4'h4, 4'h3, 3'd0, 2'd3, 1'b1};
        vecs[3] = '{4'h9, 3'd6, 4'h4, 4'h3, 3'd0, 2'd0, 1'b0};
        vecs[4] = '{4'h8, 3'd1, 4'h8, 4'h3, 3'd0, 2'd1, 1'b0};
        vecs[5] = '{4'h2, 3'd2, 4'h8, 4'h2, 3'd0, 2'd2, 1'b0};
        vecs[6] = '{4'hc, 3'd5, 4'h8, 4'h2, 3'd5, 2'd3, 1'b1};
        vecs[7] = '{4'hf, 3'd7, 4'h8, 4'h2, 3'd5, 2'd0, 1'b0};
        vecs[8] = '{4'h6, 3'd3, 4'h6, 4'h2, 3'd5, 2'd1, 1'b0};

        // Full load, wrap from READY, reload
        do_reset();
        for (int i = 0; i < 9; i++) begin
            sw    = vecs[i].sw;
            op_sw = vecs[i].op_sw;
            press_load(6);
            chk("tbl_a",     32'(a),     32'(vecs[i].ea));
            chk("tbl_b",     32'(b),     32'(vecs[i].eb));
            chk("tbl_op",    32'(op),    32'(vecs[i].eop));
            chk("tbl_stage", 32'(stage), 32'(vecs[i].est));
            chk("tbl_valid", 32'(valid), 32'(vecs[i].ev));
            if (i == 2) chk("alu_sum", 32'(4'(a + b)), 32'h7);
        end

        // Bounce rejected, then one pulse with fixed latency
        do_reset();
        btn_load = 1'b1; tick();
        btn_load = 1'b0; tick();
        btn_load = 1'b1; tick();
        btn_load = 1'b0;
        repeat (6) tick();
        chk("bounce_stage", 32'(stage), 32'h0);
        btn_load = 1'b1;
        repeat (DEB + 2) tick();
        chk("lat_before", 32'(stage), 32'h0);
        tick();
        chk("lat_capture", 32'(stage), 32'h1);
        tick();
        btn_load = 1'b0;
        repeat (10) tick();
        chk("hold_one_pulse", 32'(stage), 32'h1);

        // Clear mid-sequence
        do_reset();
        sw = 4'h9;
        press_load(5);
        chk("clr_pre_a",     32'(a),     32'h9);
        chk("clr_pre_stage", 32'(stage), 32'h1);
        press_clear(5);
        chk("clr_a",     32'(a),     32'h0);
        chk("clr_stage", 32'(stage), 32'h0);
        chk("clr_valid", 32'(valid), 32'h0);
        sw = 4'hf;
        press_load(5);
        chk("clr_reload_a", 32'(a), 32'hf);

        // Simultaneous clear and load in LOAD_OP
        do_reset();
        sw = 4'h5; press_load(5);
        sw = 4'ha; press_load(5);
        chk("sim_pre_stage", 32'(stage), 32'h2);
        op_sw = 3'd7;
        btn_load = 1'b1;
        btn_clear = 1'b1;
        repeat (6) tick();
        btn_load = 1'b0;
        btn_clear = 1'b0;
        repeat (DEB + 4) tick();
        chk("sim_stage", 32'(stage), 32'h0);
        chk("sim_op",    32'(op),    32'h0);
        chk("sim_valid", 32'(valid), 32'h0);
        chk("sim_a",     32'(a),     32'h0);

        // Reach READY, then async reset between edges (zeros checked in do_reset)
        sw = 4'h5; press_load(5);
        sw = 4'h3; press_load(5);
        op_sw = 3'd4; press_load(5);
        chk("ready_valid", 32'(valid), 32'h1);
        chk("ready_op",    32'(op),    32'h4);

        // Button held through reset release: exactly one pulse
        btn_load = 1'b1;
        do_reset();
        repeat (DEB + 2) tick();
        chk("rst_hold_before", 32'(stage), 32'h0);
        tick();
        chk("rst_hold_capture", 32'(stage), 32'h1);
        repeat (20) tick();
        btn_load = 1'b0;
        repeat (DEB + 4) tick();
        chk("rst_hold_once", 32'(stage), 32'h1);

        // Random segments of button activity against the model
        do_reset();
        for (int seg = 0; seg < 90; seg++) begin
            int dur;
            btn_load  = 1'($urandom_range(0, 1));
            btn_clear = ($urandom_range(0, 6) == 0);
            dur = int'($urandom_range(1, 9));
            for (int c = 0; c < dur; c++) begin
                sw    = 4'($urandom);
                op_sw = 3'($urandom);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
